// File: rtl/ps2_pkg.sv
// Shared types and scan-code constants for the PS/2 set-2 scan decoder.
package ps2_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DATA   = 2'd1,
      ST_PARITY = 2'd2,
      ST_STOP   = 2'd3
   } frame_state_t;

   localparam logic [7:0] SC_SPACE = 8'h29;
   localparam logic [7:0] SC_ENTER = 8'h5A;
   localparam logic [7:0] SC_ONE   = 8'h16;
   localparam logic [7:0] SC_TWO   = 8'h1E;
   localparam logic [7:0] SC_EXT   = 8'hE0;
   localparam logic [7:0] SC_BRK   = 8'hF0;

   // One-hot key index {space, enter, one, two}; only enter exists in the E0 page.
   function automatic logic [3:0] key_onehot(input logic [7:0] code, input logic ext);
      key_onehot = 4'b0000;
      if (ext) begin
         key_onehot[2] = (code == SC_ENTER);
      end else begin
         key_onehot[3] = (code == SC_SPACE);
         key_onehot[2] = (code == SC_ENTER);
         key_onehot[1] = (code == SC_ONE);
         key_onehot[0] = (code == SC_TWO);
      end
   endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Synchronises the PS/2 line pair, debounces the clock and flags its falling edges.
module ps2_line_filter
   import ps2_pkg::*;
#(
   parameter int FILTER_LEN = 8
) (
   input  logic clk,
   input  logic reset_n,
   input  logic ps2_clk,
   input  logic ps2_dat,
   output logic fall,
   output logic dat
);

   localparam int FW = $clog2(FILTER_LEN + 1);

   logic [1:0]    clk_sync;
   logic [1:0]    dat_sync;
   logic          filt;
   logic [FW-1:0] cnt;

   assign dat = dat_sync[1];

   // Idle line level is high, so everything resets to 1 to avoid a false edge.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         clk_sync <= 2'b11;
         dat_sync <= 2'b11;
         filt     <= 1'b1;
         cnt      <= '0;
         fall     <= 1'b0;
      end else begin
         clk_sync <= {clk_sync[0], ps2_clk};
         dat_sync <= {dat_sync[0], ps2_dat};
         fall     <= 1'b0;
         if (clk_sync[1] == filt) begin
            cnt <= '0;
         end else if (cnt == FW'(FILTER_LEN - 1)) begin
            filt <= clk_sync[1];
            cnt  <= '0;
            fall <= ~clk_sync[1];
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/ps2_scan_decoder.sv
// PS/2 set-2 frame receiver with prefix, break and typematic-repeat handling
// for the four reaction-benchmark keys.
module ps2_scan_decoder
   import ps2_pkg::*;
#(
   parameter int FILTER_LEN     = 8,
   parameter int TIMEOUT_CYCLES = 50000
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       ps2_clk,
   input  logic       ps2_dat,
   output logic       scan_code_ready,
   output logic [7:0] scan_code,
   output logic       space_pressed,
   output logic       enter_pressed,
   output logic       one_pressed,
   output logic       two_pressed,
   output logic       frame_error
);

   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   logic          fall;
   logic          dat;
   frame_state_t  state;
   logic [2:0]    bit_cnt;
   logic [7:0]    shreg;
   logic          par;
   logic [TW-1:0] tcnt;
   logic          ext;
   logic          brk;
   logic [3:0]    held;
   logic [3:0]    flags;

   logic       byte_ok;
   logic       byte_bad;
   logic       timeout;
   logic [3:0] key;
   logic       ignore;

   ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_filter (
      .clk     (clk),
      .reset_n (reset_n),
      .ps2_clk (ps2_clk),
      .ps2_dat (ps2_dat),
      .fall    (fall),
      .dat     (dat)
   );

   assign byte_ok  = fall && (state == ST_STOP) && dat && (^{shreg, par});
   assign byte_bad = fall && (((state == ST_STOP) && !byte_ok) ||
                              ((state == ST_IDLE) && dat));
   assign timeout  = !fall && (state != ST_IDLE) && (tcnt == TW'(TIMEOUT_CYCLES - 1));
   assign key      = key_onehot(shreg, ext);
   assign ignore   = ext && (shreg != SC_ENTER);

   assign {space_pressed, enter_pressed, one_pressed, two_pressed} = flags;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state           <= ST_IDLE;
         bit_cnt         <= '0;
         shreg           <= '0;
         par             <= 1'b0;
         tcnt            <= '0;
         ext             <= 1'b0;
         brk             <= 1'b0;
         held            <= '0;
         flags           <= '0;
         scan_code       <= '0;
         scan_code_ready <= 1'b0;
         frame_error     <= 1'b0;
      end else begin
         scan_code_ready <= 1'b0;
         frame_error     <= 1'b0;

         if (fall || state == ST_IDLE) tcnt <= '0;
         else                          tcnt <= tcnt + 1'b1;

         if (fall) begin
            case (state)
               ST_IDLE: begin
                  bit_cnt <= '0;
                  if (!dat) state <= ST_DATA;
               end
               ST_DATA: begin
                  shreg   <= {dat, shreg[7:1]};
                  bit_cnt <= bit_cnt + 1'b1;
                  if (bit_cnt == 3'd7) state <= ST_PARITY;
               end
               ST_PARITY: begin
                  par   <= dat;
                  state <= ST_STOP;
               end
               default: state <= ST_IDLE;
            endcase
         end

         if (timeout) state <= ST_IDLE;

         if (byte_bad || timeout) begin
            frame_error <= 1'b1;
            ext         <= 1'b0;
            brk         <= 1'b0;
         end else if (byte_ok) begin
            if (shreg == SC_EXT) begin
               ext <= 1'b1;
            end else if (shreg == SC_BRK) begin
               brk <= 1'b1;
            end else begin
               ext <= 1'b0;
               brk <= 1'b0;
               if (!ignore) begin
                  // Held bits suppress typematic repeats until the matching break.
                  if (brk) begin
                     held <= held & ~key;
                  end else if ((held & key) == 4'b0000) begin
                     held            <= held | key;
                     flags           <= key;
                     scan_code       <= shreg;
                     scan_code_ready <= 1'b1;
                  end
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_ps2_scan_decoder.sv
// Directed bench for ps2_scan_decoder: drives PS/2 frames bit by bit and checks strobes and flags.
module tb_ps2_scan_decoder;

   localparam int HALF = 30;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       ps2_clk = 1'b1;
   logic       ps2_dat = 1'b1;
   logic       scan_code_ready;
   logic [7:0] scan_code;
   logic       space_pressed, enter_pressed, one_pressed, two_pressed;
   logic       frame_error;

   int n_chk = 0;
   int n_pass = 0;
   int rdy_cnt = 0;
   int err_cnt = 0;
   int multi_hot = 0;
   int adjacent = 0;
   int r0, e0;
   logic prev_rdy = 1'b0;

   ps2_scan_decoder dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .ps2_clk         (ps2_clk),
      .ps2_dat         (ps2_dat),
      .scan_code_ready (scan_code_ready),
      .scan_code       (scan_code),
      .space_pressed   (space_pressed),
      .enter_pressed   (enter_pressed),
      .one_pressed     (one_pressed),
      .two_pressed     (two_pressed),
      .frame_error     (frame_error)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (scan_code_ready) rdy_cnt++;
      if (frame_error) err_cnt++;
      if (scan_code_ready && prev_rdy) adjacent++;
      if ($countones({space_pressed, enter_pressed, one_pressed, two_pressed}) > 1) multi_hot++;
      prev_rdy = scan_code_ready;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic send_bit(input logic b);
      @(negedge clk) ps2_dat = b;
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b0;
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b1;
   endtask

   task automatic send_byte(input logic [7:0] b, input logic bad_par);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(b[i]);
      send_bit(bad_par ? ^b : ~^b);
      send_bit(1'b1);
      repeat (2 * HALF) @(negedge clk);
   endtask

   function automatic logic [3:0] flg();
      return {space_pressed, enter_pressed, one_pressed, two_pressed};
   endfunction

   initial begin
      repeat (5) @(negedge clk);
      chk("reset_outputs", {scan_code, flg(), scan_code_ready, frame_error}, 32'h0);
      reset_n = 1'b1;
      repeat (20) @(negedge clk);

      // single space make
      send_byte(8'h29, 1'b0);
      chk("space_strobes", rdy_cnt, 1);
      chk("space_code", scan_code, 8'h29);
      chk("space_flags", flg(), 4'b1000);

      // enter with typematic repeats and a release in between
      r0 = rdy_cnt;
      send_byte(8'h5A, 1'b0);
      chk("enter_code", scan_code, 8'h5A);
      send_byte(8'h5A, 1'b0);
      send_byte(8'h5A, 1'b0);
      chk("enter_repeat_suppressed", rdy_cnt - r0, 1);
      send_byte(8'hF0, 1'b0);
      send_byte(8'h5A, 1'b0);
      send_byte(8'h5A, 1'b0);
      chk("enter_two_strobes", rdy_cnt - r0, 2);
      chk("enter_flags", flg(), 4'b0100);

      // extended enter, then ignored extended code
      send_byte(8'hF0, 1'b0);
      send_byte(8'h5A, 1'b0);
      r0 = rdy_cnt;
      send_byte(8'hE0, 1'b0);
      send_byte(8'h5A, 1'b0);
      chk("ext_enter_strobe", rdy_cnt - r0, 1);
      chk("ext_enter_flags", flg(), 4'b0100);
      send_byte(8'hE0, 1'b0);
      send_byte(8'h75, 1'b0);
      chk("ext75_no_strobe", rdy_cnt - r0, 1);
      chk("ext75_code_held", scan_code, 8'h5A);

      // parity error, then a good two
      r0 = rdy_cnt; e0 = err_cnt;
      send_byte(8'h16, 1'b1);
      chk("parity_err", err_cnt - e0, 1);
      chk("parity_no_strobe", rdy_cnt - r0, 0);
      chk("parity_one_flag", one_pressed, 1'b0);
      send_byte(8'h1E, 1'b0);
      chk("two_strobe", rdy_cnt - r0, 1);
      chk("two_flags", flg(), 4'b0001);
      chk("two_code", scan_code, 8'h1E);

      // release space, then a truncated frame that must time out
      send_byte(8'hF0, 1'b0);
      send_byte(8'h29, 1'b0);
      e0 = err_cnt;
      send_bit(1'b0);
      for (int i = 0; i < 4; i++) send_bit(1'b1);
      repeat (49000) @(negedge clk);
      chk("no_early_timeout", err_cnt - e0, 0);
      repeat (1200) @(negedge clk);
      chk("timeout_err", err_cnt - e0, 1);
      r0 = rdy_cnt;
      send_byte(8'h29, 1'b0);
      chk("post_timeout_strobe", rdy_cnt - r0, 1);
      chk("post_timeout_flags", flg(), 4'b1000);

      // reset mid-frame with space still held
      send_bit(1'b0);
      for (int i = 0; i < 4; i++) send_bit(1'b1);
      @(negedge clk) reset_n = 1'b0;
      ps2_dat = 1'b1;
      #1;
      chk("midframe_reset_outputs", {scan_code, flg(), scan_code_ready, frame_error}, 32'h0);
      repeat (5) @(negedge clk);
      reset_n = 1'b1;
      repeat (20) @(negedge clk);
      r0 = rdy_cnt; e0 = err_cnt;
      send_byte(8'h29, 1'b0);
      chk("post_reset_strobe", rdy_cnt - r0, 1);
      chk("post_reset_flags", flg(), 4'b1000);
      chk("post_reset_no_err", err_cnt - e0, 0);

      chk("never_multi_hot", multi_hot, 0);
      chk("never_adjacent", adjacent, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/ps2_scan_decoder.md
# ps2_scan_decoder

Receives the raw PS/2 keyboard line pair, deserialises scan-code set 2 frames, and resolves prefix, break and typematic-repeat handling. Emits a one-cycle `scan_code_ready` strobe with one-hot key flags for the four keys used by the reaction-time benchmark: space, enter, 1 and 2. Sits directly upstream of the keyboard controller FSM and drives its `scan_code_ready`, `space_pressed`, `enter_pressed`, `one_pressed` and `two_pressed` inputs.

## Interface
- `FILTER_LEN`, default 8: consecutive identical `clk` samples required before the filtered PS/2 clock changes level.
- `TIMEOUT_CYCLES`, default 50000: `clk` cycles with no filtered falling edge before an in-progress frame is aborted (1 ms at 50 MHz).
- `clk` input 1: system clock.
- `reset_n` input 1: reset, asynchronous, active-low. Clock is `clk`.
- `ps2_clk` input 1: raw PS/2 clock, asynchronous to `clk`.
- `ps2_dat` input 1: raw PS/2 data, asynchronous to `clk`.
- `scan_code_ready` output 1: one-cycle strobe marking a new accepted make event.
- `scan_code` output 8: last accepted make code; held between strobes.
- `space_pressed` output 1: last accepted code was 0x29; held between strobes.
- `enter_pressed` output 1: last accepted code was 0x5A or E0 5A; held.
- `one_pressed` output 1: last accepted code was 0x16; held.
- `two_pressed` output 1: last accepted code was 0x1E; held.
- `frame_error` output 1: one-cycle strobe on parity, stop, start or timeout error.

## Operation
- Input conditioning:
  - `ps2_clk` and `ps2_dat` each pass through 2-flop synchronisers.
  - Synchronised `ps2_clk` passes through the `FILTER_LEN` glitch filter.
  - A filtered 1→0 transition produces `fall`, a one-cycle pulse.
  - Data is sampled from synchronised `ps2_dat` on `fall`.
- Frame FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: on `fall`, data=0 → DATA with bit counter 0. Data=1 → `frame_error`, stay IDLE.
  - DATA: on each `fall`, shift the bit in LSB-first. After the 8th bit → PARITY.
  - PARITY: on `fall`, capture the bit. The 8 data bits plus parity must have odd weight. → STOP.
  - STOP: on `fall`, if data=1 and parity is OK, the byte is valid; otherwise `frame_error`. → IDLE in both cases.
- Byte interpretation (valid bytes only):
  - 0xE0: set `ext`.
  - 0xF0: set `brk`.
  - Any other byte is a code, interpreted with the current flags:
    - `brk`=1: clear the held bit for that key. No strobe.
    - `brk`=0 and the code is not held: set the held bit, pulse `scan_code_ready`, update `scan_code` and the flags.
    - `brk`=0 and the held bit is already set: typematic repeat, suppressed.
  - `ext` and `brk` clear after every code byte.
  - Held bits are tracked only for the four benchmark keys. Other make codes always strobe, with all four flags 0.
  - E0-prefixed codes other than 0x5A are ignored entirely: no strobe, no held update.
- Errors:
  - Any `frame_error` discards the byte and clears `ext` and `brk`. Held bits are kept.
  - Timeout: in DATA, PARITY or STOP, if `TIMEOUT_CYCLES` elapse without `fall`, pulse `frame_error` and → IDLE. The counter resets on every `fall` and in IDLE.

## Timing
- Reset values:
  - All outputs 0, including `scan_code` = 0x00.
  - FSM in IDLE; `ext`, `brk`, held bits, filter and counters cleared.
  - Reset mid-frame drops the partial frame with no strobe.
- Latency:
  - `scan_code_ready` and `frame_error` assert exactly 1 `clk` after the `fall` cycle that samples the stop bit.
  - Flags and `scan_code` change in that same cycle and hold until the next strobe.
- Input latency: raw edge to `fall` is 2 synchroniser cycles plus `FILTER_LEN`, plus 1.
- Strobes are never adjacent. The minimum spacing is one full PS/2 frame.
- Flag outputs are one-hot or all zero, never multi-hot.

## Structure
- Package `ps2_pkg`:
  - Frame FSM state enum.
  - Scan-code constants SC_SPACE 0x29, SC_ENTER 0x5A, SC_ONE 0x16, SC_TWO 0x1E, SC_EXT 0xE0, SC_BRK 0xF0.
- Sub-module `ps2_line_filter`:
  - Synchronisers, `FILTER_LEN` filter and falling-edge detect.
  - Outputs `fall` and synchronised data.
- The top level holds the frame FSM, timeout counter, prefix and held logic, and output registers.

## Test plan
- Frame 0x29 with correct parity → one `scan_code_ready` pulse, `space_pressed`=1, `scan_code`=0x29, other flags 0.
- 0x5A, 0x5A, 0x5A, then F0 5A, then 0x5A → exactly two strobes, both with `enter_pressed`=1.
- E0 5A → strobe with `enter_pressed`=1. E0 75 → no strobe.
- 0x16 sent with even parity → `frame_error` pulse, no strobe, `one_pressed` unchanged. The next good 0x1E → strobe with `two_pressed`=1.
- Start bit plus 4 bits, then line idle for 50000 cycles → `frame_error` at timeout. The next good 0x29 frame decodes correctly.
- `reset_n` asserted mid-frame after a prior 0x29 → all outputs 0. The next 0x29 strobes, because held bits were cleared.
